// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, access width codes,
// request owner and the fetch-starvation streak limit.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Matches funct3[1:0] of RISC-V loads/stores.
   typedef enum logic [1:0] {
      W_BYTE = 2'b00,
      W_HALF = 2'b01,
      W_WORD = 2'b10
   } width_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   localparam logic [2:0] STREAK_LIMIT = 3'd4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory (slave).
// Request fields are registered by the master; ack and rdata are valid together.
interface mem_arbiter_if;

   logic        m_req;
   logic        m_we;
   logic [1:0]  m_width;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   modport master (
      output m_req, m_we, m_width, m_addr, m_wdata,
      input  m_ack, m_rdata
   );

   modport slave (
      input  m_req, m_we, m_width, m_addr, m_wdata,
      output m_ack, m_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port, one access outstanding at a time.
// Optional `define MEM_ARB_STARVE_GUARD_EN lets a fetch win after 4 straight data grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          halt,

   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_width,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,

   mem_arbiter_if.master mem
);

   state_t      state_q, state_d;
   owner_t      owner_q;
   logic [31:0] rdata_q;
   logic        fetch_ok;
   logic        fetch_first;

   assign fetch_ok = if_req & ~halt;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] streak_q;

   // Counts back-to-back data grants that left a fetch waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
      end else if (if_gnt) begin
         streak_q <= '0;
      end else if (d_gnt) begin
         if (!if_req)
            streak_q <= '0;
         else if (streak_q != STREAK_LIMIT)
            streak_q <= streak_q + 3'd1;
      end
   end

   assign fetch_first = fetch_ok & (streak_q == STREAK_LIMIT);
`else
   assign fetch_first = 1'b0;
`endif

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: each combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (if_gnt || d_gnt) state_d = ST_BUSY;
         ST_BUSY: if (mem.m_ack)        state_d = ST_RESP;
         ST_RESP:                       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // Grants and responses are masked while rst is high so an access granted or
   // completing in the reset cycle is dropped cleanly.
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
      if (!rst) begin
         unique case (state_q)
            ST_IDLE: begin
               if (d_req && !fetch_first)
                  d_gnt = 1'b1;
               else if (fetch_ok)
                  if_gnt = 1'b1;
            end
            ST_RESP: begin
               if (owner_q == OWN_DATA) begin
                  d_rvalid = 1'b1;
                  d_rdata  = rdata_q;
               end else begin
                  if_rvalid = 1'b1;
                  if_rdata  = rdata_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Request fields latch at the grant edge and hold until m_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q     <= OWN_FETCH;
         rdata_q     <= '0;
         mem.m_req   <= 1'b0;
         mem.m_we    <= 1'b0;
         mem.m_width <= '0;
         mem.m_addr  <= '0;
         mem.m_wdata <= '0;
      end else if (d_gnt) begin
         owner_q     <= OWN_DATA;
         mem.m_req   <= 1'b1;
         mem.m_we    <= d_we;
         mem.m_width <= d_width;
         mem.m_addr  <= d_addr;
         mem.m_wdata <= d_wdata;
      end else if (if_gnt) begin
         owner_q     <= OWN_FETCH;
         mem.m_req   <= 1'b1;
         mem.m_we    <= 1'b0;
         mem.m_width <= W_WORD;
         mem.m_addr  <= if_addr;
         mem.m_wdata <= '0;
      end else if (state_q == ST_BUSY && mem.m_ack) begin
         mem.m_req <= 1'b0;
         rdata_q   <= mem.m_we ? 32'd0 : mem.m_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single accesses plus
// hand-written collision, halt, reset-abandon and streak-guard sequences.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_width;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   mem_arbiter_if mem_bus ();

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_width   (d_width),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem       (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_data;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic        is_data;
      logic        we;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_rdata;
      int          ack_delay;
      logic [31:0] exp_rdata;
   } vec_t;

   int    tests;
   int    fails;
   resp_t sb_q[$];
   bit    glog[$];   // 1 = data grant, 0 = fetch grant
   int    gcyc[$];
   logic  cur_data;
   logic  cur_we;
   vec_t  vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_resp(input logic is_data, input logic [31:0] data);
      resp_t r;
      r.is_data = is_data;
      r.data    = data;
      sb_q.push_back(r);
   endtask

   // Response monitor: every rvalid must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (if_gnt || d_gnt) begin
         check("gnt_onehot", {31'd0, if_gnt & d_gnt}, 32'd0);
         check("gnt_only_idle", {29'd0, mem_bus.m_req, if_rvalid, d_rvalid}, 32'd0);
      end
      if (if_rvalid || d_rvalid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            check("rvalid_owner", {30'd0, if_rvalid, d_rvalid}, e.is_data ? 32'd1 : 32'd2);
            check("rdata", e.is_data ? d_rdata : if_rdata, e.data);
            check("nonowner_rdata", e.is_data ? if_rdata : d_rdata, 32'd0);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.is_data) begin
         d_req = 1'b1; d_we = v.we; d_width = v.width; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      check({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, v.is_data ? 32'd1 : 32'd2);
      step();
      // Scramble the request fields: the memory port must keep the latched copy.
      d_req = 1'b0; if_req = 1'b0;
      d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom; d_width = 2'b11;
      for (int i = 0; i <= v.ack_delay; i++) begin
         check({tag, "_m_req"},   {31'd0, mem_bus.m_req}, 32'd1);
         check({tag, "_m_we"},    {31'd0, mem_bus.m_we}, v.is_data ? {31'd0, v.we} : 32'd0);
         check({tag, "_m_width"}, {30'd0, mem_bus.m_width}, v.is_data ? {30'd0, v.width} : 32'd2);
         check({tag, "_m_addr"},  mem_bus.m_addr, v.addr);
         check({tag, "_m_wdata"}, mem_bus.m_wdata, v.is_data ? v.wdata : 32'd0);
         if (i < v.ack_delay) step();
      end
      mem_bus.m_ack   = 1'b1;
      mem_bus.m_rdata = v.mem_rdata;
      push_resp(v.is_data, v.exp_rdata);
      step();
      mem_bus.m_ack   = 1'b0;
      mem_bus.m_rdata = $urandom;
      check({tag, "_m_req_drop"}, {31'd0, mem_bus.m_req}, 32'd0);
      step();
   endtask

   // Free-running memory that acks in the first BUSY cycle; logs grants.
   task automatic auto_run(input int n, input bit drop_d, input bit drop_f);
      bit d_pend, f_pend;
      d_pend = 1'b0;
      f_pend = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (d_pend) d_req = 1'b0;
         if (f_pend) if_req = 1'b0;
         d_pend = 1'b0;
         f_pend = 1'b0;
         mem_bus.m_ack   = mem_bus.m_req;
         mem_bus.m_rdata = $urandom;
         if (mem_bus.m_req) push_resp(cur_data, cur_we ? 32'd0 : mem_bus.m_rdata);
         #1;
         if (d_gnt) begin
            glog.push_back(1'b1); gcyc.push_back(c);
            cur_data = 1'b1; cur_we = d_we; d_pend = drop_d;
         end else if (if_gnt) begin
            glog.push_back(1'b0); gcyc.push_back(c);
            cur_data = 1'b0; cur_we = 1'b0; f_pend = drop_f;
         end
         step();
      end
      if (d_pend) d_req = 1'b0;
      if (f_pend) if_req = 1'b0;
      mem_bus.m_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests = 0; fails = 0;
      cur_data = 1'b0; cur_we = 1'b0;
      halt = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_width = '0; d_addr = '0; d_wdata = '0;
      mem_bus.m_ack = 1'b0; mem_bus.m_rdata = '0;

      vecs[0] = '{is_data:1'b0, we:1'b0, width:2'd2, addr:32'h0000_0100, wdata:32'h0,
                  mem_rdata:32'h0050_0093, ack_delay:0, exp_rdata:32'h0050_0093};
      vecs[1] = '{is_data:1'b1, we:1'b0, width:2'd2, addr:32'h0000_0010, wdata:32'h0,
                  mem_rdata:32'h1234_5678, ack_delay:0, exp_rdata:32'h1234_5678};
      vecs[2] = '{is_data:1'b1, we:1'b1, width:2'd2, addr:32'h0000_0020, wdata:32'hDEAD_BEEF,
                  mem_rdata:32'hFFFF_FFFF, ack_delay:5, exp_rdata:32'h0};
      vecs[3] = '{is_data:1'b1, we:1'b0, width:2'd0, addr:32'h0000_0033, wdata:32'h0,
                  mem_rdata:32'h0000_00A5, ack_delay:2, exp_rdata:32'h0000_00A5};
      vecs[4] = '{is_data:1'b1, we:1'b1, width:2'd1, addr:32'h0000_0042, wdata:32'h0000_BEEF,
                  mem_rdata:32'h0000_0001, ack_delay:1, exp_rdata:32'h0};
      vecs[5] = '{is_data:1'b0, we:1'b0, width:2'd2, addr:32'hFFFF_FFFC, wdata:32'h0,
                  mem_rdata:32'h0000_006F, ack_delay:3, exp_rdata:32'h0000_006F};

      // Reset state
      rst = 1'b1;
      step();
      step();
      check("rst_m_req",   {31'd0, mem_bus.m_req}, 32'd0);
      check("rst_m_we",    {31'd0, mem_bus.m_we}, 32'd0);
      check("rst_m_width", {30'd0, mem_bus.m_width}, 32'd0);
      check("rst_m_addr",  mem_bus.m_addr, 32'd0);
      check("rst_m_wdata", mem_bus.m_wdata, 32'd0);
      check("rst_rvalid",  {30'd0, if_rvalid, d_rvalid}, 32'd0);
      check("rst_rdata",   if_rdata | d_rdata, 32'd0);
      check("rst_gnt",     {30'd0, if_gnt, d_gnt}, 32'd0);
      rst = 1'b0;

      // m_ack while idle must be ignored
      mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'hBAD0_BAD0;
      step(); step(); step();
      mem_bus.m_ack = 1'b0;
      check("idle_ack_m_req", {31'd0, mem_bus.m_req}, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Collision: data first, fetch granted in the IDLE right after d_rvalid
      glog.delete(); gcyc.delete();
      if_req = 1'b1; if_addr = 32'h0000_0200;
      d_req = 1'b1; d_we = 1'b0; d_width = 2'd2; d_addr = 32'h0000_0010;
      auto_run(10, 1'b1, 1'b1);
      check("coll_count", glog.size(), 32'd2);
      if (glog.size() == 2) begin
         check("coll_first_data", {31'd0, glog[0]}, 32'd1);
         check("coll_then_fetch", {31'd0, glog[1]}, 32'd0);
         check("coll_fetch_cycle", gcyc[1] - gcyc[0], 32'd3);
      end

      // halt blocks fetch for 10 cycles while a store is served
      glog.delete(); gcyc.delete();
      halt = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0300;
      d_req = 1'b1; d_we = 1'b1; d_width = 2'd2; d_wdata = 32'h0BAD_F00D; d_addr = 32'h0000_0080;
      auto_run(10, 1'b1, 1'b1);
      check("halt_count", glog.size(), 32'd1);
      if (glog.size() >= 1) check("halt_data_served", {31'd0, glog[0]}, 32'd1);
      halt = 1'b0;
      auto_run(4, 1'b1, 1'b1);
      check("unhalt_count", glog.size(), 32'd2);
      if (glog.size() >= 2) check("unhalt_fetch", {31'd0, glog[1]}, 32'd0);

      // In-flight fetch completes even if halt rises during BUSY
      if_req = 1'b1; if_addr = 32'h0000_0400;
      #1;
      check("inflight_gnt", {31'd0, if_gnt}, 32'd1);
      step();
      if_req = 1'b0; halt = 1'b1;
      mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'h0000_0013;
      push_resp(1'b0, 32'h0000_0013);
      step();
      mem_bus.m_ack = 1'b0;
      step();
      halt = 1'b0;

      // Reset in BUSY abandons the access
      d_req = 1'b1; d_we = 1'b0; d_width = 2'd2; d_addr = 32'h0000_0040;
      #1;
      check("rbusy_gnt", {31'd0, d_gnt}, 32'd1);
      step();
      d_req = 1'b0;
      check("rbusy_m_req", {31'd0, mem_bus.m_req}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rbusy_m_req_drop", {31'd0, mem_bus.m_req}, 32'd0);
      check("rbusy_m_addr_clr", mem_bus.m_addr, 32'd0);
      mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'hCAFE_0001;
      step(); step();
      mem_bus.m_ack = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0500;
      #1;
      check("rbusy_idle_gnt", {31'd0, if_gnt}, 32'd1);
      step();
      if_req = 1'b0;
      mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'h0000_0093;
      push_resp(1'b0, 32'h0000_0093);
      step();
      mem_bus.m_ack = 1'b0;
      step();

      // Reset in RESP suppresses the response pulse
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0044;
      step();
      d_req = 1'b0;
      mem_bus.m_ack = 1'b1; mem_bus.m_rdata = 32'h5555_5555;
      step();
      mem_bus.m_ack = 1'b0;
      rst = 1'b1;
      #1;
      check("rresp_no_rvalid", {31'd0, d_rvalid}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // Streak guard: both requests held constant for ten grants
      do_reset();
      glog.delete(); gcyc.delete();
      if_req = 1'b1; if_addr = 32'h0000_0600;
      d_req = 1'b1; d_we = 1'b0; d_width = 2'd2; d_addr = 32'h0000_0060;
      auto_run(30, 1'b0, 1'b0);
      if_req = 1'b0; d_req = 1'b0;
      check("guard_count", glog.size(), 32'd10);
      for (int i = 0; i < glog.size() && i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         check($sformatf("guard_grant%0d", i), {31'd0, glog[i]}, (i % 5 == 4) ? 32'd0 : 32'd1);
`else
         check($sformatf("guard_grant%0d", i), {31'd0, glog[i]}, 32'd1);
`endif
      end
      step(); step();

      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
